// File: rtl/miriscv_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle over a
// (XLEN+1)-bit signed multiplicand and multiplier, producing the low 2*XLEN product bits.
module miriscv_seq_mult #(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                req_i,
    input  logic [XLEN:0]       ai,
    input  logic [XLEN:0]       bi,
    input  logic                zf,
    input  logic                kill_i,
    output logic [2*XLEN-1:0]   r,
    output logic                rdy,
    output logic                busy_o,
    output logic [1:0]          dbg_state_o
);

    // Handshake: the requester raises req_i with stable operands and keeps them
    // until it samples rdy high; rdy is a one-cycle pulse, and a req_i still high
    // in the IDLE cycle after DONE starts a new operation.

    localparam int OPW  = XLEN + 3;
    localparam int ITER = (XLEN + 3) / 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [OPW-1:0]     acc_q, acc_d;
    logic [OPW-1:0]     mplr_q, mplr_d;
    logic [OPW-1:0]     mcand_q, mcand_d;
    logic [2*XLEN-1:0]  r_q, r_d;
    logic               rdy_q;

    logic [OPW-1:0]     addend;
    logic [OPW-1:0]     sum;
    logic [2*OPW-1:0]   shifted;
    logic [OPW-1:0]     acc_step;
    logic [OPW-1:0]     mplr_step;

    // mplr_q holds {multiplier, q_-1}; its low three bits select the Booth digit.
    always_comb begin
        addend = '0;
        unique case (mplr_q[2:0])
            3'b001, 3'b010: addend = mcand_q;
            3'b011:         addend = mcand_q << 1;
            3'b100:         addend = -(mcand_q << 1);
            3'b101, 3'b110: addend = -mcand_q;
            default:        addend = '0;
        endcase
    end

    assign sum       = acc_q + addend;
    assign shifted   = $signed({sum, mplr_q}) >>> 2;
    assign acc_step  = shifted[2*OPW-1:OPW];
    assign mplr_step = shifted[OPW-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        mcand_d = mcand_q;
        r_d     = r_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i && !kill_i) begin
                    if (zf) begin
                        r_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        mcand_d = {{2{ai[XLEN]}}, ai};
                        mplr_d  = {bi[XLEN], bi, 1'b0};
                        acc_d   = '0;
                        cnt_d   = CW'(ITER);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d  = acc_step;
                    mplr_d = mplr_step;
                    cnt_d  = cnt_q - CW'(1);
                    // Last digit retires this cycle; the product is {acc, multiplier} after the shift.
                    if (cnt_q == CW'(1)) begin
                        r_d     = {acc_step[XLEN-3:0], mplr_step[OPW-1:1]};
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            mcand_q <= '0;
            r_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            mcand_q <= mcand_d;
            r_q     <= r_d;
            rdy_q   <= (state_d == S_DONE);
        end
    end

    assign r           = r_q;
    assign rdy         = rdy_q;
    assign busy_o      = (state_q == S_CALC);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_miriscv_seq_mult.sv
// Directed bench for miriscv_seq_mult: hand-computed products, latency,
// kill, zero-flag, back-to-back and asynchronous-reset behaviour.
module tb_miriscv_seq_mult;

    localparam int XLEN = 32;

    logic              clk_i;
    logic              arstn_i;
    logic              req_i;
    logic [XLEN:0]     ai;
    logic [XLEN:0]     bi;
    logic              zf;
    logic              kill_i;
    logic [2*XLEN-1:0] r;
    logic              rdy;
    logic              busy_o;
    logic [1:0]        dbg_state_o;

    int checks   = 0;
    int failures = 0;

    miriscv_seq_mult #(.XLEN(XLEN)) dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .req_i       (req_i),
        .ai          (ai),
        .bi          (bi),
        .zf          (zf),
        .kill_i      (kill_i),
        .r           (r),
        .rdy         (rdy),
        .busy_o      (busy_o),
        .dbg_state_o (dbg_state_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [XLEN:0] a, input logic [XLEN:0] b, input logic z);
        req_i = 1'b1;
        ai    = a;
        bi    = b;
        zf    = z;
    endtask

    // Ticks the acceptance edge, then waits (bounded) for rdy.
    task automatic wait_rdy(input int exp_lat, input logic [63:0] exp_r, input string tag,
                            input logic scramble);
        int          n;
        logic        saw_busy;
        logic        r_held;
        logic [63:0] r_prev;
        r_prev   = r;
        r_held   = 1'b1;
        tick();
        n        = 1;
        saw_busy = busy_o;
        if (scramble) begin
            ai = {$urandom_range(0, 1), $urandom()};
            bi = {$urandom_range(0, 1), $urandom()};
        end
        while (!rdy && n < 40) begin
            if (r !== r_prev) r_held = 1'b0;
            tick();
            n++;
            if (busy_o && !rdy) saw_busy = 1'b1;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_r"}, r, exp_r);
        check({tag, "_busy_seen"}, {63'd0, saw_busy}, {63'd0, exp_lat > 1});
        check({tag, "_r_held"}, {63'd0, r_held}, 64'd1);
    endtask

    task automatic finish_op(input string tag);
        req_i = 1'b0;
        tick();
        check({tag, "_rdy_drop"}, {63'd0, rdy}, 64'd0);
        check({tag, "_idle"}, {62'd0, dbg_state_o}, 64'd0);
    endtask

    initial begin
        int rdy_pulses;
        arstn_i = 1'b0;
        req_i   = 1'b0;
        ai      = '0;
        bi      = '0;
        zf      = 1'b0;
        kill_i  = 1'b0;
        tick();
        tick();
        check("reset_r", r, 64'd0);
        check("reset_rdy", {63'd0, rdy}, 64'd0);
        check("reset_busy", {63'd0, busy_o}, 64'd0);
        arstn_i = 1'b1;
        tick();

        start(33'h0_0000_0007, 33'h0_0000_0006, 1'b0);
        wait_rdy(18, 64'h0000_0000_0000_002A, "mul_7x6", 1'b0);
        finish_op("mul_7x6");

        start(33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0);
        wait_rdy(18, 64'h0000_0000_0000_0001, "mul_m1xm1", 1'b0);
        finish_op("mul_m1xm1");

        start(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0);
        wait_rdy(18, 64'hFFFF_FFFE_0000_0001, "mul_umax_sq_scrambled", 1'b1);
        finish_op("mul_umax_sq");

        start(33'h1_8000_0000, 33'h1_8000_0000, 1'b0);
        wait_rdy(18, 64'h4000_0000_0000_0000, "mul_smin_sq", 1'b0);
        finish_op("mul_smin_sq");

        start(33'h1_FFFF_FFFF, 33'h0_0000_0005, 1'b0);
        wait_rdy(18, 64'hFFFF_FFFF_FFFF_FFFB, "mul_m1x5", 1'b0);
        finish_op("mul_m1x5");

        start(33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0);
        wait_rdy(18, 64'hFFFF_FFFF_0000_0001, "mul_umax_xm1", 1'b0);
        finish_op("mul_umax_xm1");

        start(33'h1_8000_0000, 33'h0_7FFF_FFFF, 1'b0);
        wait_rdy(18, 64'hC000_0000_8000_0000, "mul_smin_xsmax", 1'b0);
        finish_op("mul_smin_xsmax");

        start(33'h0_8000_0000, 33'h0_FFFF_FFFF, 1'b0);
        wait_rdy(18, 64'h7FFF_FFFF_8000_0000, "mul_2p31_xumax", 1'b0);
        finish_op("mul_2p31_xumax");

        start(33'h0_0000_0000, 33'h0_1234_5678, 1'b1);
        wait_rdy(1, 64'd0, "zf_op", 1'b0);
        finish_op("zf_op");
        zf = 1'b0;

        start(33'h0_0000_0003, 33'h0_0000_0005, 1'b0);
        kill_i = 1'b1;
        tick();
        tick();
        check("kill_idle_busy", {63'd0, busy_o}, 64'd0);
        check("kill_idle_state", {62'd0, dbg_state_o}, 64'd0);
        kill_i = 1'b0;
        req_i  = 1'b0;

        start(33'h0_0000_0007, 33'h0_0000_0006, 1'b0);
        wait_rdy(18, 64'd42, "pre_kill_42", 1'b0);
        finish_op("pre_kill_42");
        start(33'h0_0000_0003, 33'h0_0000_0005, 1'b0);
        tick();
        rdy_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (rdy) rdy_pulses++;
            tick();
        end
        kill_i = 1'b1;
        check("kill_calc_busy", {63'd0, busy_o}, 64'd1);
        tick();
        kill_i = 1'b0;
        if (rdy) rdy_pulses++;
        check("kill_calc_no_rdy", 64'(rdy_pulses), 64'd0);
        check("kill_calc_r_kept", r, 64'd42);
        check("kill_calc_idle", {62'd0, dbg_state_o}, 64'd0);
        wait_rdy(18, 64'd15, "after_kill_3x5", 1'b0);
        kill_i = 1'b1;
        req_i  = 1'b0;
        check("kill_done_rdy", {63'd0, rdy}, 64'd1);
        tick();
        kill_i = 1'b0;
        check("kill_done_idle", {62'd0, dbg_state_o}, 64'd0);
        check("kill_done_rdy_drop", {63'd0, rdy}, 64'd0);

        start(33'h0_0000_0007, 33'h0_0000_0006, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) tick();
        check("rst_mid_busy_before", {63'd0, busy_o}, 64'd1);
        #2 arstn_i = 1'b0;
        #1;
        check("rst_mid_r", r, 64'd0);
        check("rst_mid_rdy", {63'd0, rdy}, 64'd0);
        check("rst_mid_busy", {63'd0, busy_o}, 64'd0);
        req_i = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        rdy_pulses = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rdy) rdy_pulses++;
        end
        check("rst_mid_no_rdy", 64'(rdy_pulses), 64'd0);

        start(33'h0_0000_0003, 33'h0_0000_0005, 1'b0);
        wait_rdy(18, 64'd15, "b2b_first", 1'b0);
        ai = 33'h0_0000_0007;
        bi = 33'h0_0000_0006;
        tick();
        check("b2b_gap_idle", {62'd0, dbg_state_o}, 64'd0);
        check("b2b_gap_busy", {63'd0, busy_o}, 64'd0);
        check("b2b_gap_rdy", {63'd0, rdy}, 64'd0);
        wait_rdy(18, 64'd42, "b2b_second", 1'b0);
        finish_op("b2b_second");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
